byte_serializer: RTL and testbench

//   Splits one wide word into BEATS narrow beats, LSB beat first, presented as a valid-qualified stream

---
 rtl/ser_pkg.sv | 28 ++
 rtl/byte_serializer_if.sv | 30 +++
 rtl/ser_hold_buf.sv | 54 +++++
 rtl/byte_serializer.sv | 126 ++++++++++++
 tb/tb_byte_serializer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the byte serializer slice.
//   DATA_W   : width of one output beat
//   BEATS    : beats per input word (must be >= 2)
//   CNT_W    : width of the beat counter
//   WORD_W   : width of one input word
//   ser_state_e : serializer state (idle / sending a word)
//   get_beat : selects beat idx of a word, beat 0 being the least significant
// ----------------------------------------------------------------------------
package ser_pkg;

    localparam int DATA_W = 8;
    localparam int BEATS  = 4;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int WORD_W = DATA_W * BEATS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    function automatic logic [DATA_W-1:0] get_beat(input logic [WORD_W-1:0] word,
                                                   input logic [CNT_W-1:0]  idx);
        return word[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// ----------------------------------------------------------------------------
// byte_serializer_if
// Groups the upstream word handshake and the downstream beat stream.
//   word_in/valid_in/ready_up          : upstream word transfer
//   data_out/valid_out/last_out        : downstream beat stream
//   ready_down                         : downstream backpressure
// The slave modport is the serializer's view, master is the environment's.
// ----------------------------------------------------------------------------
interface byte_serializer_if;
    import ser_pkg::*;

    logic [WORD_W-1:0] word_in;
    logic              valid_in;
    logic              ready_up;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              last_out;
    logic              ready_down;

    modport master (
        output word_in, valid_in, ready_down,
        input  ready_up, data_out, valid_out, last_out
    );

    modport slave (
        input  word_in, valid_in, ready_down,
        output ready_up, data_out, valid_out, last_out
    );

endinterface

// File: rtl/ser_hold_buf.sv
// ----------------------------------------------------------------------------
// ser_hold_buf
// One-entry holding register that parks the next word while the current word
// is being serialized. No datapath logic beyond storage.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : store word_i (wins over pop_i, so pop+push leaves it full)
//   pop_i      : release the stored word
//   word_i     : word to store
//   word_o     : stored word
//   full_o     : an entry is held
// ----------------------------------------------------------------------------
module ser_hold_buf
    import ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o
);

    logic              full_q, full_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Next-state for the entry: a push always leaves the buffer full with the
    // new word, even when the old word is popped at the same edge.
    always_comb begin
        full_d = full_q;
        word_d = word_q;
        if (push_i) begin
            full_d = 1'b1;
            word_d = word_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // Storage registers, cleared and marked empty on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    assign full_o = full_q;

endmodule

// File: rtl/byte_serializer.sv
// ----------------------------------------------------------------------------
// byte_serializer
// Splits one WORD_W word into BEATS beats of DATA_W, LSB beat first, as a
// valid-qualified registered stream with downstream backpressure. A one-word
// holding buffer lets the next word be accepted while the current one is sent,
// so consecutive words leave with no idle cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : byte_serializer_if.slave (word_in, valid_in, ready_up,
//                data_out, valid_out, last_out, ready_down)
// ----------------------------------------------------------------------------
module byte_serializer
    import ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    byte_serializer_if.slave  bus
);

    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    logic              holdFull;
    logic [WORD_W-1:0] holdWord;
    logic              holdPush;
    logic              holdPop;

    logic              busy;
    logic              accept;
    logic              beatXfer;
    logic              atLast;
    logic              shregFree;
    logic [CNT_W-1:0]  cntNext;
    logic              loadEn;
    logic [WORD_W-1:0] loadWord;

    ser_hold_buf u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (holdPush),
        .pop_i  (holdPop),
        .word_i (bus.word_in),
        .word_o (holdWord),
        .full_o (holdFull)
    );

    // ready_up comes straight from the hold flag so it never depends on
    // valid_in. The shift register frees up either when idle or when its
    // final beat is taken at this edge.
    assign busy      = (state_q == S_SEND);
    assign accept    = bus.valid_in && !holdFull;
    assign beatXfer  = busy && bus.ready_down;
    assign atLast    = (cnt_q == CNT_W'(BEATS-1));
    assign shregFree = !busy || (beatXfer && atLast);
    assign cntNext   = cnt_q + CNT_W'(1);

    // Next-state logic. The buffered word has priority over the incoming one
    // so order is preserved; an accepted word that cannot be loaded right away
    // is parked in the hold buffer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        last_d   = last_q;
        holdPush = 1'b0;
        holdPop  = 1'b0;
        loadEn   = 1'b0;
        loadWord = holdWord;

        if (shregFree) begin
            if (holdFull) begin
                loadEn   = 1'b1;
                loadWord = holdWord;
                holdPop  = 1'b1;
                holdPush = accept;
            end else if (accept) begin
                loadEn   = 1'b1;
                loadWord = bus.word_in;
            end else begin
                state_d = S_IDLE;
                last_d  = 1'b0;
            end
        end else begin
            holdPush = accept;
            if (beatXfer) begin
                cnt_d  = cntNext;
                data_d = get_beat(shreg_q, cntNext);
                last_d = (cntNext == CNT_W'(BEATS-1));
            end
        end

        if (loadEn) begin
            state_d = S_SEND;
            cnt_d   = '0;
            shreg_d = loadWord;
            data_d  = get_beat(loadWord, '0);
            last_d  = 1'b0;
        end
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign bus.ready_up  = !holdFull;
    assign bus.data_out  = data_q;
    assign bus.valid_out = busy;
    assign bus.last_out  = last_q;

endmodule

// File: tb/tb_byte_serializer.sv
// ----------------------------------------------------------------------------
// tb_byte_serializer
// Drives the serializer through directed scenarios and a randomized run,
// comparing the beat stream against a queue of expected beats built from the
// accepted words.
// ----------------------------------------------------------------------------
module tb_byte_serializer;
    import ser_pkg::*;

    logic clk;
    logic rst_n;
    int   nTests;
    int   nFail;

    // Each entry is {last, data}
    logic [DATA_W:0] expQ[$];
    logic [DATA_W:0] gotQ[$];

    byte_serializer_if bus ();

    byte_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Just before the edge, an accepted word is expanded
    // into its beats (LSB beat first, last flag on the top beat) and a taken
    // beat is logged. Returns 1 time unit after the edge.
    task automatic cycle();
        if (rst_n && bus.valid_in && bus.ready_up)
            for (int k = 0; k < BEATS; k++)
                expQ.push_back({(k == BEATS-1), bus.word_in[k*DATA_W +: DATA_W]});
        if (rst_n && bus.valid_out && bus.ready_down)
            gotQ.push_back({bus.last_out, bus.data_out});
        @(posedge clk);
        #1;
    endtask

    // Reset values and idle behaviour
    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_down = 1'b0;
        bus.word_in = '0;
        cycle();
        cycle();
        nTests++; if (bus.valid_out !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b, expected 0", bus.valid_out); end
        nTests++; if (bus.last_out !== 1'b0) begin nFail++; $display("[TB] FAIL reset_last: got %b, expected 0", bus.last_out); end
        nTests++; if (bus.data_out !== 8'h00) begin nFail++; $display("[TB] FAIL reset_data: got %h, expected 00", bus.data_out); end
        nTests++; if (bus.ready_up !== 1'b1) begin nFail++; $display("[TB] FAIL reset_ready: got %b, expected 1", bus.ready_up); end
        rst_n = 1'b1;
        cycle();
        nTests++; if (bus.valid_out !== 1'b0) begin nFail++; $display("[TB] FAIL idle_valid: got %b, expected 0", bus.valid_out); end
        expQ.delete();
        gotQ.delete();
    endtask

    // One word, ready_down held high: four consecutive beats then idle
    task automatic test_single_word();
        logic [7:0] e;
        bus.ready_down = 1'b1;
        bus.word_in = 32'h04030201;
        bus.valid_in = 1'b1;
        cycle();
        bus.valid_in = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            e = 8'(k + 1);
            nTests++; if (bus.valid_out !== 1'b1) begin nFail++; $display("[TB] FAIL single_valid[%0d]: got %b, expected 1", k, bus.valid_out); end
            nTests++; if (bus.data_out !== e) begin nFail++; $display("[TB] FAIL single_data[%0d]: got %h, expected %h", k, bus.data_out, e); end
            nTests++; if (bus.last_out !== (k == BEATS-1)) begin nFail++; $display("[TB] FAIL single_last[%0d]: got %b, expected %b", k, bus.last_out, (k == BEATS-1)); end
            cycle();
        end
        nTests++; if (bus.valid_out !== 1'b0) begin nFail++; $display("[TB] FAIL single_end_valid: got %b, expected 0", bus.valid_out); end
        expQ.delete();
        gotQ.delete();
    endtask

    // Two words back to back: eight contiguous beats 11..88
    task automatic test_back_to_back();
        logic [7:0] e;
        bus.ready_down = 1'b1;
        bus.word_in = 32'h44332211;
        bus.valid_in = 1'b1;
        cycle();
        for (int i = 0; i < 2*BEATS; i++) begin
            if (i == 0) begin
                bus.word_in = 32'h88776655;
                nTests++; if (bus.ready_up !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_ready: got %b, expected 1", bus.ready_up); end
            end
            e = 8'((i + 1) * 17);
            nTests++; if (bus.valid_out !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_valid[%0d]: got %b, expected 1", i, bus.valid_out); end
            nTests++; if (bus.data_out !== e) begin nFail++; $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", i, bus.data_out, e); end
            nTests++; if (bus.last_out !== ((i % BEATS) == BEATS-1)) begin nFail++; $display("[TB] FAIL b2b_last[%0d]: got %b", i, bus.last_out); end
            cycle();
            bus.valid_in = 1'b0;
        end
        nTests++; if (bus.valid_out !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_end_valid: got %b, expected 0", bus.valid_out); end
        expQ.delete();
        gotQ.delete();
    endtask

    // Backpressure for three cycles on beat BB: it must hold steady
    task automatic test_stall();
        bus.ready_down = 1'b1;
        bus.word_in = 32'hDDCCBBAA;
        bus.valid_in = 1'b1;
        cycle();
        bus.valid_in = 1'b0;
        cycle();
        bus.ready_down = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            nTests++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hBB || bus.last_out !== 1'b0) begin
                nFail++; $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h l=%b, expected v=1 d=bb l=0", i, bus.valid_out, bus.data_out, bus.last_out);
            end
            if (i < 3) cycle();
        end
        bus.ready_down = 1'b1;
        cycle();
        nTests++; if (bus.data_out !== 8'hCC) begin nFail++; $display("[TB] FAIL stall_resume_cc: got %h, expected cc", bus.data_out); end
        cycle();
        nTests++; if (bus.data_out !== 8'hDD || bus.last_out !== 1'b1) begin nFail++; $display("[TB] FAIL stall_resume_dd: got %h/%b, expected dd/1", bus.data_out, bus.last_out); end
        cycle();
        nTests++; if (gotQ.size() != 4) begin nFail++; $display("[TB] FAIL stall_count: got %0d, expected 4", gotQ.size()); end
        else foreach (gotQ[i]) begin
            nTests++; if (gotQ[i] !== expQ[i]) begin nFail++; $display("[TB] FAIL stall_beat[%0d]: got %h, expected %h", i, gotQ[i], expQ[i]); end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    // Stalled output, hold fills, third word waits; all three emerge in order
    task automatic test_hold_full();
        logic [WORD_W-1:0] w1;
        logic accepted;
        w1 = $urandom();
        bus.ready_down = 1'b0;
        bus.word_in = w1;
        bus.valid_in = 1'b1;
        cycle();
        bus.word_in = $urandom();
        nTests++; if (bus.ready_up !== 1'b1) begin nFail++; $display("[TB] FAIL hold_ready_empty: got %b, expected 1", bus.ready_up); end
        cycle();
        bus.word_in = $urandom();
        for (int i = 0; i < 3; i++) begin
            nTests++; if (bus.ready_up !== 1'b0) begin nFail++; $display("[TB] FAIL hold_ready_full[%0d]: got %b, expected 0", i, bus.ready_up); end
            nTests++; if (bus.valid_out !== 1'b1 || bus.data_out !== w1[7:0]) begin nFail++; $display("[TB] FAIL hold_beat0[%0d]: got %b/%h, expected 1/%h", i, bus.valid_out, bus.data_out, w1[7:0]); end
            cycle();
        end
        bus.ready_down = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (bus.ready_up) accepted = 1'b1;
            cycle();
        end
        bus.valid_in = 1'b0;
        nTests++; if (!accepted) begin nFail++; $display("[TB] FAIL hold_third_accept: got timeout, expected accept"); end
        for (int i = 0; i < 40 && bus.valid_out; i++) cycle();
        nTests++; if (bus.valid_out !== 1'b0) begin nFail++; $display("[TB] FAIL hold_drain: got valid %b, expected 0", bus.valid_out); end
        nTests++; if (gotQ.size() != expQ.size() || gotQ.size() != 3*BEATS) begin nFail++; $display("[TB] FAIL hold_count: got %0d, expected %0d", gotQ.size(), 3*BEATS); end
        else foreach (gotQ[i]) begin
            nTests++; if (gotQ[i] !== expQ[i]) begin nFail++; $display("[TB] FAIL hold_beat[%0d]: got %h, expected %h", i, gotQ[i], expQ[i]); end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    // Reset mid-word with the hold full: nothing stale may follow
    task automatic test_mid_reset();
        logic stale;
        bus.ready_down = 1'b1;
        bus.word_in = $urandom();
        bus.valid_in = 1'b1;
        cycle();
        bus.word_in = $urandom();
        cycle();
        bus.valid_in = 1'b0;
        cycle();
        nTests++; if (bus.ready_up !== 1'b0) begin nFail++; $display("[TB] FAIL mreset_hold_full: got %b, expected 0", bus.ready_up); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        nTests++; if (bus.valid_out !== 1'b0 || bus.last_out !== 1'b0 || bus.data_out !== 8'h00 || bus.ready_up !== 1'b1) begin
            nFail++; $display("[TB] FAIL mreset_outputs: got v=%b l=%b d=%h r=%b, expected v=0 l=0 d=00 r=1", bus.valid_out, bus.last_out, bus.data_out, bus.ready_up);
        end
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.valid_out) stale = 1'b1;
            cycle();
        end
        nTests++; if (stale) begin nFail++; $display("[TB] FAIL mreset_stale: got stale beat, expected none"); end
        nTests++; if (gotQ.size() != 2) begin nFail++; $display("[TB] FAIL mreset_count: got %0d, expected 2", gotQ.size()); end
        else foreach (gotQ[i]) begin
            nTests++; if (gotQ[i] !== expQ[i]) begin nFail++; $display("[TB] FAIL mreset_beat[%0d]: got %h, expected %h", i, gotQ[i], expQ[i]); end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    // Feed a 4-beat accumulator: per-word sums of the beat stream
    task automatic test_accumulator();
        int sums[$];
        int acc;
        bus.ready_down = 1'b1;
        bus.word_in = 32'hFFFFFFFF;
        bus.valid_in = 1'b1;
        cycle();
        bus.word_in = 32'h01020304;
        cycle();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 40 && bus.valid_out; i++) cycle();
        acc = 0;
        foreach (gotQ[i]) begin
            acc += int'(gotQ[i][DATA_W-1:0]);
            if (gotQ[i][DATA_W]) begin
                sums.push_back(acc);
                acc = 0;
            end
        end
        nTests++; if (sums.size() != 2) begin nFail++; $display("[TB] FAIL acc_words: got %0d, expected 2", sums.size()); end
        else begin
            nTests++; if (sums[0] != 1020) begin nFail++; $display("[TB] FAIL acc_sum0: got %0d, expected 1020", sums[0]); end
            nTests++; if (sums[1] != 10) begin nFail++; $display("[TB] FAIL acc_sum1: got %0d, expected 10", sums[1]); end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    // Random valid/ready/word traffic; stalled beats must stay put and the
    // whole stream must match the accepted words
    task automatic test_random();
        logic prevStall;
        logic [DATA_W-1:0] prevData;
        logic prevLast;
        prevStall = 1'b0;
        prevData = '0;
        prevLast = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (prevStall) begin
                nTests++; if (bus.valid_out !== 1'b1 || bus.data_out !== prevData || bus.last_out !== prevLast) begin
                    nFail++; $display("[TB] FAIL rand_stall[%0d]: got v=%b d=%h l=%b, expected v=1 d=%h l=%b", c, bus.valid_out, bus.data_out, bus.last_out, prevData, prevLast);
                end
            end
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.word_in = $urandom();
            bus.ready_down = ($urandom_range(0, 3) != 0);
            prevStall = bus.valid_out && !bus.ready_down;
            prevData = bus.data_out;
            prevLast = bus.last_out;
            cycle();
        end
        bus.valid_in = 1'b0;
        bus.ready_down = 1'b1;
        for (int i = 0; i < 40 && bus.valid_out; i++) cycle();
        nTests++; if (bus.valid_out !== 1'b0) begin nFail++; $display("[TB] FAIL rand_drain: got valid %b, expected 0", bus.valid_out); end
        nTests++; if (gotQ.size() != expQ.size()) begin nFail++; $display("[TB] FAIL rand_count: got %0d, expected %0d", gotQ.size(), expQ.size()); end
        else foreach (gotQ[i]) begin
            nTests++; if (gotQ[i] !== expQ[i]) begin nFail++; $display("[TB] FAIL rand_beat[%0d]: got %h, expected %h", i, gotQ[i], expQ[i]); end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    // Scenario sequence and summary
    initial begin
        nTests = 0;
        nFail = 0;
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_down = 1'b0;
        bus.word_in = '0;
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_hold_full();
        test_mid_reset();
        test_accumulator();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
